// File: rtl/atm_session_arbiter.sv
// rtl/atm_session_arbiter.sv - round-robin arbiter sequencing terminal transactions into one ATM core
module atm_session_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_ACC     = 10,
    parameter int CORE_CYCLES = 4,
    parameter int MAX_FAILS   = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [3*NUM_REQ-1:0]       req_operation,
    input  logic [4*NUM_REQ-1:0]       req_acc_num,
    input  logic [16*NUM_REQ-1:0]      req_pin,
    input  logic [16*NUM_REQ-1:0]      req_new_pin,
    input  logic [32*NUM_REQ-1:0]      req_amount,
    input  logic [NUM_REQ-1:0]         req_language,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [31:0]                resp_balance,
    output logic                       resp_success,
    output logic                       resp_locked,
    output logic                       core_rst,
    output logic [2:0]                 core_operation,
    output logic [3:0]                 core_acc_num,
    output logic [15:0]                core_pin,
    output logic [15:0]                core_new_pin,
    output logic [31:0]                core_amount,
    output logic                       core_language,
    input  logic [31:0]                core_balance,
    input  logic                       core_success
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (CORE_CYCLES > 1) ? $clog2(CORE_CYCLES) : 1;
    localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAILS);
    localparam logic [CW-1:0] RUN_LAST = CW'(CORE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] cur_id;
    logic [CW-1:0]  run_cnt;
    logic           ran;
    logic [31:0]    res_balance;
    logic           res_success;
    logic           res_locked;
    logic [1:0]     fail_cnt [NUM_ACC];

    logic               found;
    logic [IDW-1:0]     pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic [2:0]         sel_op;
    logic [3:0]         sel_acc;
    logic [15:0]        sel_pin;
    logic [15:0]        sel_new_pin;
    logic [31:0]        sel_amount;
    logic               sel_language;
    logic               fields_ok;
    logic               acc_locked;

    // Two passes: first the terminals at or above the pointer, then the wrapped-around ones.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
    end

    always_comb begin
        pick_oh      = '0;
        sel_op       = '0;
        sel_acc      = '0;
        sel_pin      = '0;
        sel_new_pin  = '0;
        sel_amount   = '0;
        sel_language = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && (pick == IDW'(i))) begin
                pick_oh[i]   = 1'b1;
                sel_op       = req_operation[3*i +: 3];
                sel_acc      = req_acc_num[4*i +: 4];
                sel_pin      = req_pin[16*i +: 16];
                sel_new_pin  = req_new_pin[16*i +: 16];
                sel_amount   = req_amount[32*i +: 32];
                sel_language = req_language[i];
            end
        end
    end

    always_comb begin
        fields_ok = (core_operation >= 3'd3) && (core_operation <= 3'd6) &&
                    (core_acc_num != 4'd0) && (int'(core_acc_num) <= NUM_ACC);
        acc_locked = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if ((core_acc_num == 4'(i + 1)) && (fail_cnt[i] == FAIL_MAX)) begin
                acc_locked = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ptr            <= '0;
            cur_id         <= '0;
            run_cnt        <= '0;
            ran            <= 1'b0;
            res_balance    <= '0;
            res_success    <= 1'b0;
            res_locked     <= 1'b0;
            gnt            <= '0;
            done           <= 1'b0;
            resp_id        <= '0;
            resp_balance   <= '0;
            resp_success   <= 1'b0;
            resp_locked    <= 1'b0;
            core_rst       <= 1'b0;
            core_operation <= '0;
            core_acc_num   <= '0;
            core_pin       <= '0;
            core_new_pin   <= '0;
            core_amount    <= '0;
            core_language  <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++) begin
                fail_cnt[i] <= '0;
            end
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt            <= pick_oh;
                        cur_id         <= pick;
                        ptr            <= (pick == IDW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                        core_operation <= sel_op;
                        core_acc_num   <= sel_acc;
                        core_pin       <= sel_pin;
                        core_new_pin   <= sel_new_pin;
                        core_amount    <= sel_amount;
                        core_language  <= sel_language;
                        state          <= CHECK;
                    end
                end
                CHECK: begin
                    res_balance <= '0;
                    res_success <= 1'b0;
                    if (!fields_ok) begin
                        res_locked <= 1'b0;
                        ran        <= 1'b0;
                        state      <= RESP;
                    end else if (acc_locked) begin
                        res_locked <= 1'b1;
                        ran        <= 1'b0;
                        state      <= RESP;
                    end else begin
                        res_locked <= 1'b0;
                        ran        <= 1'b1;
                        run_cnt    <= '0;
                        core_rst   <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        res_balance <= core_balance;
                        res_success <= core_success;
                        res_locked  <= 1'b0;
                        core_rst    <= 1'b0;
                        state       <= RESP;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Response fields change together with done so they stay stable between pulses.
                    done         <= 1'b1;
                    resp_id      <= cur_id;
                    resp_balance <= res_balance;
                    resp_success <= res_success;
                    resp_locked  <= res_locked;
                    for (int i = 0; i < NUM_ACC; i++) begin
                        if (ran && (core_acc_num == 4'(i + 1))) begin
                            if (res_success) begin
                                fail_cnt[i] <= '0;
                            end else if (fail_cnt[i] != FAIL_MAX) begin
                                fail_cnt[i] <= fail_cnt[i] + 2'd1;
                            end
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_arbiter.sv
// tb/tb_atm_session_arbiter.sv - self-checking bench for atm_session_arbiter
module tb_atm_session_arbiter;

    localparam int NR = 4;
    localparam int NA = 10;
    localparam int CC = 4;
    localparam int MF = 3;
    localparam int IW = $clog2(NR);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NR-1:0]        req;
    logic [3*NR-1:0]      req_operation;
    logic [4*NR-1:0]      req_acc_num;
    logic [16*NR-1:0]     req_pin;
    logic [16*NR-1:0]     req_new_pin;
    logic [32*NR-1:0]     req_amount;
    logic [NR-1:0]        req_language;
    logic [NR-1:0]        gnt;
    logic                 done;
    logic [IW-1:0]        resp_id;
    logic [31:0]          resp_balance;
    logic                 resp_success;
    logic                 resp_locked;
    logic                 core_rst;
    logic [2:0]           core_operation;
    logic [3:0]           core_acc_num;
    logic [15:0]          core_pin;
    logic [15:0]          core_new_pin;
    logic [31:0]          core_amount;
    logic                 core_language;
    logic [31:0]          core_balance;
    logic                 core_success;

    logic [2:0]  t_op   [NR];
    logic [3:0]  t_acc  [NR];
    logic [15:0] t_pin  [NR];
    logic [15:0] t_npin [NR];
    logic [31:0] t_amt  [NR];
    logic        t_lang [NR];

    atm_session_arbiter #(.NUM_REQ(NR), .NUM_ACC(NA), .CORE_CYCLES(CC), .MAX_FAILS(MF)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_operation(req_operation), .req_acc_num(req_acc_num), .req_pin(req_pin),
        .req_new_pin(req_new_pin), .req_amount(req_amount), .req_language(req_language),
        .gnt(gnt), .done(done), .resp_id(resp_id), .resp_balance(resp_balance),
        .resp_success(resp_success), .resp_locked(resp_locked), .core_rst(core_rst),
        .core_operation(core_operation), .core_acc_num(core_acc_num), .core_pin(core_pin),
        .core_new_pin(core_new_pin), .core_amount(core_amount), .core_language(core_language),
        .core_balance(core_balance), .core_success(core_success)
    );

    always_comb begin
        req_operation = '0;
        req_acc_num   = '0;
        req_pin       = '0;
        req_new_pin   = '0;
        req_amount    = '0;
        req_language  = '0;
        for (int k = 0; k < NR; k++) begin
            req_operation[3*k +: 3] = t_op[k];
            req_acc_num[4*k +: 4]   = t_acc[k];
            req_pin[16*k +: 16]     = t_pin[k];
            req_new_pin[16*k +: 16] = t_npin[k];
            req_amount[32*k +: 32]  = t_amt[k];
            req_language[k]         = t_lang[k];
        end
    end

    // Core stand-in: balance = amount + pin, success = new_pin[0]; garbage when held in reset.
    assign core_balance = core_rst ? (core_amount + {16'h0, core_pin}) : 32'hDEAD_BEEF;
    assign core_success = core_rst & core_new_pin[0];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_term(input int k, input logic [2:0] op, input logic [3:0] acc,
                            input logic [15:0] pin, input logic [15:0] npin, input logic [31:0] amt);
        t_op[IW'(k)]   = op;
        t_acc[IW'(k)]  = acc;
        t_pin[IW'(k)]  = pin;
        t_npin[IW'(k)] = npin;
        t_amt[IW'(k)]  = amt;
        t_lang[IW'(k)] = pin[1];
    endtask

    task automatic txn(input logic [NR-1:0] mask, input int k, input logic run,
                       input logic [31:0] bal, input logic succ, input logic lock, input string nm);
        int lat;
        int crst;
        req = mask;
        tick;
        chk({nm, " gnt"}, 32'(gnt), 32'(1) << k);
        chk({nm, " core_acc_num"}, 32'(core_acc_num), 32'(t_acc[IW'(k)]));
        req = '0;
        lat  = -1;
        crst = 0;
        for (int t = 1; t <= 20; t++) begin
            tick;
            if (core_rst) crst++;
            if (done) begin
                lat = t;
                break;
            end
        end
        chk({nm, " done latency"}, 32'(lat), run ? 32'(2 + CC) : 32'd2);
        chk({nm, " core_rst cycles"}, 32'(crst), run ? 32'(CC) : 32'd0);
        chk({nm, " resp_id"}, 32'(resp_id), 32'(k));
        chk({nm, " resp_balance"}, resp_balance, bal);
        chk({nm, " resp_success"}, 32'(resp_success), 32'(succ));
        chk({nm, " resp_locked"}, 32'(resp_locked), 32'(lock));
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req = '0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    typedef struct {
        int          term;
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [15:0] npin;
        logic [31:0] amt;
        logic        run;
        logic [31:0] bal;
        logic        succ;
        logic        lock;
    } vec_t;

    vec_t vec [17];

    int order [4];
    int ptr_m;
    int fails [NA];

    initial begin
        vec[0]  = '{2, 3'd3, 4'd1,  16'd1234, 16'd1, 32'd3766, 1'b1, 32'd5000, 1'b1, 1'b0};
        vec[1]  = '{1, 3'd4, 4'd4,  16'd5,    16'd0, 32'd100,  1'b1, 32'd105,  1'b0, 1'b0};
        vec[2]  = '{1, 3'd4, 4'd4,  16'd5,    16'd0, 32'd100,  1'b1, 32'd105,  1'b0, 1'b0};
        vec[3]  = '{3, 3'd4, 4'd4,  16'd5,    16'd0, 32'd100,  1'b1, 32'd105,  1'b0, 1'b0};
        vec[4]  = '{1, 3'd4, 4'd4,  16'd5,    16'd1, 32'd100,  1'b0, 32'd0,    1'b0, 1'b1};
        vec[5]  = '{0, 3'd5, 4'd5,  16'd0,    16'd0, 32'd10,   1'b1, 32'd10,   1'b0, 1'b0};
        vec[6]  = '{0, 3'd5, 4'd5,  16'd1,    16'd0, 32'd10,   1'b1, 32'd11,   1'b0, 1'b0};
        vec[7]  = '{2, 3'd6, 4'd5,  16'd2,    16'd1, 32'd20,   1'b1, 32'd22,   1'b1, 1'b0};
        vec[8]  = '{0, 3'd3, 4'd5,  16'd0,    16'd0, 32'd1,    1'b1, 32'd1,    1'b0, 1'b0};
        vec[9]  = '{0, 3'd3, 4'd5,  16'd0,    16'd0, 32'd1,    1'b1, 32'd1,    1'b0, 1'b0};
        vec[10] = '{3, 3'd3, 4'd5,  16'd0,    16'd1, 32'd7,    1'b1, 32'd7,    1'b1, 1'b0};
        vec[11] = '{1, 3'd7, 4'd2,  16'd9,    16'd1, 32'd50,   1'b0, 32'd0,    1'b0, 1'b0};
        vec[12] = '{2, 3'd3, 4'd0,  16'd9,    16'd1, 32'd50,   1'b0, 32'd0,    1'b0, 1'b0};
        vec[13] = '{3, 3'd3, 4'd11, 16'd9,    16'd1, 32'd50,   1'b0, 32'd0,    1'b0, 1'b0};
        vec[14] = '{0, 3'd2, 4'd3,  16'd9,    16'd1, 32'd50,   1'b0, 32'd0,    1'b0, 1'b0};
        vec[15] = '{1, 3'd6, 4'd10, 16'd3,    16'd1, 32'd40,   1'b1, 32'd43,   1'b1, 1'b0};
        vec[16] = '{2, 3'd3, 4'd4,  16'd3,    16'd1, 32'd40,   1'b0, 32'd0,    1'b0, 1'b1};

        for (int k = 0; k < NR; k++) set_term(k, 3'd7, 4'd0, 16'd0, 16'd0, 32'd0);

        // Reset state with all terminals requesting, then first grant goes to terminal 0.
        rst = 1'b0;
        req = 4'hF;
        tick;
        tick;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst core_rst", 32'(core_rst), 32'd0);
        chk("rst resp_balance", resp_balance, 32'd0);
        chk("rst resp_success", 32'(resp_success), 32'd0);
        chk("rst resp_locked", 32'(resp_locked), 32'd0);
        chk("rst resp_id", 32'(resp_id), 32'd0);
        chk("rst core_acc_num", 32'(core_acc_num), 32'd0);
        rst = 1'b1;
        txn(4'hF, 0, 1'b0, 32'd0, 1'b0, 1'b0, "first");

        // Round-robin with a held request vector.
        do_reset;
        for (int k = 0; k < NR; k++) set_term(k, 3'd7, 4'd1, 16'd0, 16'd0, 32'd0);
        order = '{0, 1, 3, 0};
        req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            int got_done;
            int early;
            logic [NR-1:0] seen;
            seen = '0;
            for (int w = 0; w < 10; w++) begin
                tick;
                if (gnt != '0) begin
                    seen = gnt;
                    break;
                end
            end
            chk("rr gnt", 32'(seen), 32'(1) << order[g]);
            got_done = 0;
            early    = 0;
            for (int w = 0; w < 10; w++) begin
                tick;
                if (gnt != '0) early = 1;
                if (done) begin
                    got_done = 1;
                    break;
                end
            end
            chk("rr done", 32'(got_done), 32'd1);
            chk("rr gnt before done", 32'(early), 32'd0);
        end
        req = '0;

        // Table of single transactions from fresh counters.
        do_reset;
        for (int v = 0; v < 17; v++) begin
            set_term(vec[v].term, vec[v].op, vec[v].acc, vec[v].pin, vec[v].npin, vec[v].amt);
            txn(NR'(1) << vec[v].term, vec[v].term, vec[v].run, vec[v].bal, vec[v].succ,
                vec[v].lock, $sformatf("vec%0d", v));
        end

        // Reset during the second RUN cycle abandons the transaction and unlocks account 4.
        begin
            int seen_done;
            set_term(0, 3'd3, 4'd1, 16'd0, 16'd1, 32'd5);
            req = 4'b0001;
            tick;
            chk("mid gnt", 32'(gnt), 32'd1);
            req = '0;
            tick;
            tick;
            chk("mid core_rst running", 32'(core_rst), 32'd1);
            rst = 1'b0;
            #1;
            chk("mid core_rst dropped", 32'(core_rst), 32'd0);
            seen_done = 0;
            for (int w = 0; w < 3; w++) begin
                tick;
                if (done) seen_done = 1;
            end
            chk("mid no done", 32'(seen_done), 32'd0);
            chk("mid resp_balance", resp_balance, 32'd0);
            rst = 1'b1;
            set_term(1, 3'd3, 4'd4, 16'd1, 16'd1, 32'd9);
            txn(4'b0010, 1, 1'b1, 32'd10, 1'b1, 1'b0, "after rst");
        end

        // Randomized traffic against a reference model.
        do_reset;
        ptr_m = 0;
        for (int a = 0; a < NA; a++) fails[a] = 0;
        for (int it = 0; it < 200; it++) begin
            logic [NR-1:0] mask;
            int k;
            int acc;
            int op;
            logic run;
            logic [31:0] bal;
            logic succ;
            logic lock;
            mask = NR'($urandom_range(1, 15));
            for (int j = 0; j < NR; j++) begin
                t_op[j]   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 6));
                t_acc[j]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
                t_pin[j]  = 16'($urandom);
                t_npin[j] = {15'($urandom), ($urandom_range(0, 9) < 3)};
                t_amt[j]  = $urandom;
                t_lang[j] = 1'($urandom);
            end
            k = -1;
            for (int i = 0; i < NR; i++) begin
                if (k < 0 && mask[(ptr_m + i) % NR]) k = (ptr_m + i) % NR;
            end
            ptr_m = (k + 1) % NR;
            op  = int'(t_op[IW'(k)]);
            acc = int'(t_acc[IW'(k)]);
            run = 1'b0; bal = 32'd0; succ = 1'b0; lock = 1'b0;
            if (op >= 3 && op <= 6 && acc >= 1 && acc <= NA) begin
                if (fails[acc-1] >= MF) begin
                    lock = 1'b1;
                end else begin
                    run  = 1'b1;
                    bal  = t_amt[IW'(k)] + 32'(t_pin[IW'(k)]);
                    succ = t_npin[IW'(k)][0];
                    if (succ) fails[acc-1] = 0;
                    else if (fails[acc-1] < MF) fails[acc-1]++;
                end
            end
            txn(mask, k, run, bal, succ, lock, $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
